// File: rtl/d5m_sensor_emulator.sv
// D5M parallel pixel interface transmitter model.
// Emits FVAL/LVAL/strobe framing with selectable test patterns.
module d5m_sensor_emulator #(
   parameter int ACTIVE_W  = 640,
   parameter int ACTIVE_H  = 480,
   parameter int H_BLANK   = 16,
   parameter int V_BLANK   = 32,
   parameter int FV_LV_GAP = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        enable,
   input  logic        continuous,
   input  logic        start,
   input  logic [1:0]  pattern_sel,
   input  logic [11:0] const_val,
   output logic [11:0] d5m_d,
   output logic        d5m_fval,
   output logic        d5m_lval,
   output logic        d5m_strobe,
   output logic [15:0] frame_count,
   output logic        busy
);

   localparam int XW   = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
   localparam int YW   = (ACTIVE_H > 1) ? $clog2(ACTIVE_H) : 1;
   localparam int CM1  = (V_BLANK > H_BLANK) ? V_BLANK : H_BLANK;
   localparam int CMAX = (CM1 > FV_LV_GAP) ? CM1 : FV_LV_GAP;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [XW-1:0] X_LAST  = XW'(ACTIVE_W - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(ACTIVE_H - 1);
   localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);
   localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] GP_LAST = CW'(FV_LV_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_VBLANK, S_FPRE, S_LINE, S_HBLANK, S_FPOST
   } state_t;

   state_t          state_q;
   logic [XW-1:0]   x_q;
   logic [YW-1:0]   y_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      pat_q;
   logic [11:0]     cval_q;
   logic [11:0]     fcl_q;
   logic            start_pend_q;
   logic [11:0]     d_q;
   logic            fval_q;
   logic            lval_q;
   logic            strobe_q;
   logic [15:0]     fcount_q;
   logic            busy_q;

   function automatic logic [11:0] pixel(
      input logic [1:0]    pat,
      input logic [XW-1:0] x,
      input logic [YW-1:0] y,
      input logic [11:0]   cv,
      input logic [11:0]   fc
   );
      logic [31:0] s;
      logic [11:0] p;
      s = 32'(x) + 32'(y);
      p = s[11:0];
      unique case (pat)
         2'd0: p = s[11:0];
         2'd1: begin
            if (x[0] == y[0]) p = 12'h800;
            else if (!y[0])   p = 12'hFFF;
            else              p = 12'h000;
         end
         2'd2: p = cv;
         default: p = fc;
      endcase
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         cnt_q        <= '0;
         pat_q        <= '0;
         cval_q       <= '0;
         fcl_q        <= '0;
         start_pend_q <= 1'b0;
         d_q          <= '0;
         fval_q       <= 1'b0;
         lval_q       <= 1'b0;
         strobe_q     <= 1'b0;
         fcount_q     <= '0;
         busy_q       <= 1'b0;
      end else if (!pix_en) begin
         // a start seen between pixel edges is held for the next one
         if (state_q == S_IDLE && start) start_pend_q <= 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               start_pend_q <= 1'b0;
               if (enable && (start || start_pend_q || continuous)) begin
                  state_q <= S_VBLANK;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  x_q     <= '0;
                  y_q     <= '0;
                  pat_q   <= pattern_sel;
                  cval_q  <= const_val;
                  fcl_q   <= fcount_q[11:0];
               end
            end
            S_VBLANK: begin
               if (cnt_q == VB_LAST) begin
                  state_q  <= S_FPRE;
                  cnt_q    <= '0;
                  fval_q   <= 1'b1;
                  strobe_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_FPRE: begin
               if (cnt_q == GP_LAST) begin
                  state_q <= S_LINE;
                  x_q     <= '0;
                  lval_q  <= 1'b1;
                  d_q     <= pixel(pat_q, '0, y_q, cval_q, fcl_q);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_LINE: begin
               if (x_q == X_LAST) begin
                  state_q <= (y_q == Y_LAST) ? S_FPOST : S_HBLANK;
                  cnt_q   <= '0;
                  lval_q  <= 1'b0;
                  d_q     <= '0;
               end else begin
                  x_q <= x_q + 1'b1;
                  d_q <= pixel(pat_q, x_q + 1'b1, y_q, cval_q, fcl_q);
               end
            end
            S_HBLANK: begin
               if (cnt_q == HB_LAST) begin
                  state_q  <= S_LINE;
                  x_q      <= '0;
                  y_q      <= y_q + 1'b1;
                  lval_q   <= 1'b1;
                  strobe_q <= 1'b0;
                  d_q      <= pixel(pat_q, '0, y_q + 1'b1, cval_q, fcl_q);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_FPOST: begin
               if (cnt_q == GP_LAST) begin
                  fval_q   <= 1'b0;
                  strobe_q <= 1'b0;
                  fcount_q <= fcount_q + 16'd1;
                  if (enable && continuous) begin
                     state_q <= S_VBLANK;
                     cnt_q   <= '0;
                     x_q     <= '0;
                     y_q     <= '0;
                     pat_q   <= pattern_sel;
                     cval_q  <= const_val;
                     fcl_q   <= fcount_q[11:0] + 12'd1;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign d5m_d       = d_q;
   assign d5m_fval    = fval_q;
   assign d5m_lval    = lval_q;
   assign d5m_strobe  = strobe_q;
   assign frame_count = fcount_q;
   assign busy        = busy_q;

endmodule
